// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, oversample divider helper and default clocking constants.
package uart_pkg;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD_RATE = 9600;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    int d;
    d = clk_freq / (baud_rate * oversample);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample tick divider plus sample index within a bit; restart realigns both.
module uart_os_tick #(
  parameter int DIV = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] idx
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = $clog2(OVERSAMPLE);
  logic [DW-1:0] dcnt;
  assign tick = dcnt == DW'(DIV - 1);
  always_ff @(posedge clk)
    if (reset || restart) begin
      dcnt <= '0;
      idx <= '0;
    end else if (tick) begin
      dcnt <= '0;
      idx <= idx == IW'(OVERSAMPLE - 1) ? '0 : idx + 1'b1;
    end else
      dcnt <= dcnt + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 2-of-3 mid-bit voting, valid/ready hold and overrun pulse.
// Define UART_RX_PARITY_EN to receive and check a parity bit (even/odd by PARITY_ODD).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err
);
  localparam int IW = $clog2(OVERSAMPLE);
  localparam logic [IW-1:0] S0 = IW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] S1 = IW'(OVERSAMPLE / 2);
  localparam logic [IW-1:0] S2 = IW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] LAST = IW'(OVERSAMPLE - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 ||
      OVERSAMPLE % 2 != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_os: illegal parameter value");
  end
  state_t state;
  logic rx_s1, rx_s2, rx_d, smp0, smp1, maj, restart, tick, mid, bit_end, last_stop;
  logic fe, brk, fe_fin, brk_fin;
  logic [IW-1:0] idx;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic par, pe;
`endif
  assign restart = state == IDLE && rx_d && !rx_s2;
  assign maj = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
  assign mid = tick && idx == S2;
  assign bit_end = tick && idx == LAST;
  assign last_stop = bcnt == 4'(STOP_BITS - 1);
  assign fe_fin = fe || !maj;
  // break only looks at the first stop bit
  assign brk_fin = brk && (bcnt != '0 || !maj);
  assign rx_busy = state != IDLE;
  uart_os_tick #(.DIV(calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .reset(reset), .restart(restart), .tick(tick), .idx(idx)
  );
  always_ff @(posedge clk)
    {rx_d, rx_s2, rx_s1} <= reset ? 3'b111 : {rx_s2, rx_s1, rx};
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      bcnt <= '0;
      shreg <= '0;
      {smp0, smp1} <= 2'b11;
      {fe, brk} <= 2'b00;
      rx_data <= '0;
      {rx_valid, frame_err, break_det, overrun_err} <= 4'b0000;
`ifdef UART_RX_PARITY_EN
      {par, pe, parity_err} <= 3'b000;
`endif
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tick && idx == S0) smp0 <= rx_s2;
      if (tick && idx == S1) smp1 <= rx_s2;
      case (state)
        IDLE: if (restart) begin
          state <= START;
          bcnt <= '0;
          {fe, brk} <= 2'b01;
`ifdef UART_RX_PARITY_EN
          {par, pe} <= {1'(PARITY_ODD), 1'b0};
`endif
        end
        START: if (mid && maj) state <= IDLE;
          else if (bit_end) state <= DATA;
        DATA: begin
          if (mid) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            brk <= brk && !maj;
`ifdef UART_RX_PARITY_EN
            par <= par ^ maj;
`endif
          end
          if (bit_end && bcnt == 4'(DATA_BITS - 1)) begin
            bcnt <= '0;
            state <= AFTER_DATA;
          end else if (bit_end) bcnt <= bcnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid) begin
            pe <= par ^ maj;
            brk <= brk && !maj;
          end
          if (bit_end) state <= STOP;
        end
`endif
        STOP: if (mid && last_stop) begin
          state <= IDLE;
          if (!rx_valid || rx_ready) begin
            rx_data <= shreg;
            rx_valid <= 1'b1;
            frame_err <= fe_fin;
            break_det <= brk_fin;
`ifdef UART_RX_PARITY_EN
            parity_err <= pe;
`endif
          end else overrun_err <= 1'b1;
        end else if (mid) begin
          fe <= fe_fin;
          brk <= brk_fin;
        end else if (bit_end) bcnt <= bcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: table-driven, random and corner-sequence checks of uart_rx_os at 32 clocks per bit.
module tb_uart_rx_os;
  localparam int BIT = 32;
  localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct {
    logic [7:0]  d;
    logic        pbad;
    logic        stop;
    logic [10:0] exp;
  } vec_t;
  logic clk = 0, reset = 1, rx = 1, rx_ready = 1;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, parity_err, frame_err, break_det, overrun_err;
  int vectors = 0, miscompares = 0, vcnt = 0, ocnt = 0;
  logic [10:0] q[$];
  vec_t tbl[7];
  uart_rx_os #(.CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1),
               .OVERSAMPLE(16), .PARITY_ODD(ODD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .parity_err(parity_err), .frame_err(frame_err),
    .break_det(break_det), .overrun_err(overrun_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) q.push_back({parity_err, frame_err, break_det, rx_data});
    if (rx_valid) vcnt++;
    if (overrun_err) ocnt++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [10:0] model(input logic [7:0] d, input logic pbit, input logic stop);
    logic pe;
    pe = PEN && ((($countones(d) + int'(pbit)) % 2) != ODD);
    return {pe, !stop, d == 8'h00 && !(PEN && pbit) && !stop, d};
  endfunction
  task automatic send(input logic [7:0] d, input logic pbit, input logic stop);
    rx = 0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = pbit;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1;
    repeat (2 * BIT) @(negedge clk);
  endtask
  task automatic expect_word(input string nm, input logic [10:0] exp);
    logic [11:0] got;
    got = q.size() > 0 ? {1'b1, q.pop_front()} : 12'h000;
    chk(nm, 32'(got), 32'({1'b1, exp}));
    chk({nm, "_extra"}, q.size(), 0);
  endtask
  initial begin
    logic [7:0] d;
    logic pb, st;
    tbl[0] = '{8'h55, 1'b0, 1'b1, {3'b000, 8'h55}};
    tbl[1] = '{8'h00, 1'b0, 1'b0, {3'b011, 8'h00}};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, {3'b000, 8'hFF}};
    tbl[3] = '{8'h80, 1'b0, 1'b0, {3'b010, 8'h80}};
    tbl[4] = '{8'h07, 1'b1, 1'b1, {PEN, 2'b00, 8'h07}};
    tbl[5] = '{8'h00, 1'b0, 1'b1, {3'b000, 8'h00}};
    tbl[6] = '{8'h01, 1'b0, 1'b0, {3'b010, 8'h01}};
    repeat (4) @(negedge clk);
    chk("reset_state", {rx_busy, rx_valid, overrun_err, parity_err, frame_err, break_det, rx_data}, 0);
    reset = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      vcnt = 0;
      send(tbl[i].d, (^tbl[i].d) ^ 1'(ODD) ^ tbl[i].pbad, tbl[i].stop);
      expect_word($sformatf("tbl%0d", i), tbl[i].exp);
      chk($sformatf("tbl%0d_valid_cycles", i), vcnt, 1);
    end
    rx = 0;
    repeat (BIT) @(negedge clk);
    rx = 1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("midframe_reset_clear", {rx_busy, rx_valid, parity_err, frame_err, break_det, rx_data}, 0);
    reset = 0;
    repeat (5 * BIT) @(negedge clk);
    chk("midframe_no_word", q.size(), 0);
    send(8'h12, (^8'h12) ^ 1'(ODD), 1'b1);
    expect_word("after_reset_12", {3'b000, 8'h12});
    vcnt = 0;
    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    repeat (6) @(negedge clk);
    chk("glitch_busy_high", rx_busy, 1);
    repeat (BIT) @(negedge clk);
    chk("glitch_busy_low", rx_busy, 0);
    chk("glitch_no_valid", vcnt, 0);
    rx_ready = 0;
    ocnt = 0;
    send(8'hA5, (^8'hA5) ^ 1'(ODD), 1'b1);
    send(8'h3C, (^8'h3C) ^ 1'(ODD), 1'b1);
    chk("overrun_pulses", ocnt, 1);
    chk("overrun_held", {rx_valid, rx_data}, {1'b1, 8'hA5});
    rx_ready = 1;
    repeat (2) @(negedge clk);
    expect_word("overrun_word", {3'b000, 8'hA5});
    chk("overrun_valid_clear", rx_valid, 0);
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      st = $urandom_range(0, 4) != 0;
      pb = (^d) ^ 1'(ODD) ^ ($urandom_range(0, 3) == 0);
      send(d, pb, st);
      expect_word($sformatf("rand%0d", i), model(d, pb, st));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
